hw2_pipe_monitor: RTL

Receive-side companion to `hw2_pipe`, synthesised next to it in the Design Compiler flow. It consumes the 16-bit result stream `d` together with the mode bit `s` that produced each result. It buffers the results in a small capture FIFO that a host reads out over a valid handshake, and it keeps running statistics (count, sum, min, max) so silicon and gate-level runs can be checked without a waveform dump.

---
 rtl/hw2_mon_pkg.sv | 25 ++
 rtl/hw2_pipe_monitor_if.sv | 22 ++
 rtl/hw2_mon_fifo.sv | 68 ++++++
 rtl/hw2_pipe_monitor.sv | 85 ++++++++
 4 files changed

// File: rtl/hw2_mon_pkg.sv
// Shared widths, statistic reset constants and entry layout for the
// hw2_pipe result monitor.
package hw2_mon_pkg;

   localparam int D_W     = 16;
   localparam int TAG_W   = 1;
   localparam int ENTRY_W = TAG_W + D_W;

   localparam logic [D_W-1:0] MIN_INIT = 16'hFFFF;
   localparam logic [D_W-1:0] MAX_INIT = 16'h0000;

   typedef struct packed {
      logic [TAG_W-1:0] s;
      logic [D_W-1:0]   d;
   } entry_t;

   function automatic logic [D_W-1:0] umin(input logic [D_W-1:0] a, input logic [D_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [D_W-1:0] umax(input logic [D_W-1:0] a, input logic [D_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/hw2_pipe_monitor_if.sv
// Result stream and host read handshake between hw2_pipe/host and the monitor.
interface hw2_pipe_monitor_if;
   import hw2_mon_pkg::*;

   logic [D_W-1:0]     d_in;
   logic [TAG_W-1:0]   s_in;
   logic               d_valid;
   logic               rd_en;
   logic [ENTRY_W-1:0] rd_data;
   logic               rd_valid;

   modport master (
      output d_in, s_in, d_valid, rd_en,
      input  rd_data, rd_valid
   );

   modport slave (
      input  d_in, s_in, d_valid, rd_en,
      output rd_data, rd_valid
   );

endinterface

// File: rtl/hw2_mon_fifo.sv
// Synchronous capture FIFO with registered read port; occupancy is kept as a
// separate counter so full/empty never depend on pointer comparison.
module hw2_mon_fifo
   import hw2_mon_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic [ENTRY_W-1:0]         wr_data,
   input  logic                       rd_en,
   output logic [ENTRY_W-1:0]         rd_data,
   output logic                       rd_valid,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW:0]        occ;
   logic               pop;
   logic               push;

   // A pop on a full FIFO frees the slot the same-cycle write lands in.
   assign pop  = rd_en && (occ != '0);
   assign push = wr_en && ((occ != FULL_OCC) || pop);

   assign empty     = (occ == '0);
   assign full      = (occ == FULL_OCC);
   assign occupancy = occ;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         occ      <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= pop;
         if (pop) begin
            rd_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + AW'(1);
         end
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   occ <= occ + (AW+1)'(1);
            2'b01:   occ <= occ - (AW+1)'(1);
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: rtl/hw2_pipe_monitor.sv
// Receive-side monitor for hw2_pipe: capture FIFO plus running count/sum/min/max
// statistics that also see samples the FIFO had to drop.
module hw2_pipe_monitor
   import hw2_mon_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int SUM_W = 24
) (
   input  logic                clk,
   input  logic                reset,
   hw2_pipe_monitor_if.slave   bus,
   input  logic                clear,
   output logic                empty,
   output logic                full,
   output logic                overflow,
   output logic [15:0]         count,
   output logic [SUM_W-1:0]    sum,
   output logic [D_W-1:0]      min_d,
   output logic [D_W-1:0]      max_d
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

   logic [AW:0] occupancy;
   logic        drop;
   entry_t      wr_entry;

   assign wr_entry = '{s: bus.s_in, d: bus.d_in};

   hw2_mon_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (bus.d_valid),
      .wr_data   (wr_entry),
      .rd_en     (bus.rd_en),
      .rd_data   (bus.rd_data),
      .rd_valid  (bus.rd_valid),
      .empty     (empty),
      .full      (full),
      .occupancy (occupancy)
   );

   // A full FIFO is never empty, so any rd_en there is a real pop.
   assign drop = bus.d_valid && (occupancy == FULL_OCC) && !bus.rd_en;

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (clear) begin
         overflow <= drop;
      end else if (drop) begin
         overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         sum   <= '0;
         min_d <= MIN_INIT;
         max_d <= MAX_INIT;
      end else if (bus.d_valid) begin
         if (clear) begin
            count <= 16'd1;
            sum   <= SUM_W'(bus.d_in);
            min_d <= bus.d_in;
            max_d <= bus.d_in;
         end else begin
            count <= (count == '1) ? count : count + 16'd1;
            sum   <= sum + SUM_W'(bus.d_in);
            min_d <= umin(min_d, bus.d_in);
            max_d <= umax(max_d, bus.d_in);
         end
      end else if (clear) begin
         count <= '0;
         sum   <= '0;
         min_d <= MIN_INIT;
         max_d <= MAX_INIT;
      end
   end

endmodule
